// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/[MEM]/WB with sticky HALT on faults.
// Latency: 4 cycles per ALU instruction, 5 per load/store, plus one cycle per ack delay.
// Backpressure: waits in FETCH/MEM on imem_ack/dmem_ack; bounded by TIMEOUT (0 = unbounded).
module mc_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        dec_illegal,
  input  logic        dec_mem_rren,
  input  logic        dec_mem_wren,
  input  logic        dec_gp_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        alu_en,
  output logic        gp_we_out,
  output logic        pc_we,
  output logic [2:0]  state,
  output logic [1:0]  halt_cause,
  output logic [31:0] retired
);

  // Wait counter only needs to reach TIMEOUT-1 before the fault fires.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_HALT   = 3'b111
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     retired_q, retired_d;
  logic [1:0]      cause_q, cause_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            rren_q, rren_d;
  logic            wren_q, wren_d;
  logic            gpwe_q, gpwe_d;
  logic            wait_expired;

  // Fault fires on the cycle the counter would reach TIMEOUT; an ack in that cycle wins.
  assign wait_expired = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // State register plus the datapath registers it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
      cause_q   <= 2'b00;
      wait_q    <= '0;
      rren_q    <= 1'b0;
      wren_q    <= 1'b0;
      gpwe_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
      rren_q    <= rren_d;
      wren_q    <= wren_d;
      gpwe_q    <= gpwe_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  begin
        if (imem_ack)          state_d = S_DECODE;
        else if (wait_expired) state_d = S_HALT;
      end
      S_DECODE: state_d = dec_illegal ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (rren_q || wren_q) ? S_MEM : S_WB;
      S_MEM:    begin
        if (dmem_ack)          state_d = S_WB;
        else if (wait_expired) state_d = S_HALT;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values: IR capture, decoder flag latch, fault cause, retire count, wait counter.
  always_comb begin
    ir_d      = ir_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    rren_d    = rren_q;
    wren_d    = wren_q;
    gpwe_d    = gpwe_q;
    wait_d    = '0;
    if (state_q == S_FETCH && imem_ack) ir_d = imem_rdata;
    if (state_q == S_DECODE) begin
      rren_d = dec_mem_rren;
      wren_d = dec_mem_wren;
      gpwe_d = dec_gp_we;
      if (dec_illegal) cause_d = 2'b01;
    end
    if (state_q == S_FETCH && !imem_ack && wait_expired) cause_d = 2'b10;
    if (state_q == S_MEM && !dmem_ack && wait_expired)   cause_d = 2'b11;
    if (state_q == S_WB) retired_d = retired_q + 32'd1;
    // Counter runs only while staying in a wait state; any entry clears it.
    if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q)
      wait_d = wait_q + CW'(1);
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    dmem_req  = (state_q == S_MEM);
    dmem_we   = (state_q == S_MEM) && wren_q;
    alu_en    = (state_q == S_EXEC);
    pc_we     = (state_q == S_WB);
    gp_we_out = (state_q == S_WB) && gpwe_q;
    state     = state_q;
    ir        = ir_q;
    halt_cause = cause_q;
    retired   = retired_q;
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized bench for mc_sequencer with a sequence-level reference model.
// Latency: checks every cycle of every instruction against the expected state trace.
// Backpressure: ack delays randomized within the TIMEOUT budget; faults exercised explicitly.
module tb_mc_sequencer;

  localparam int unsigned TO = 4;
  localparam logic [2:0] E_IDLE = 3'b000, E_FETCH = 3'b001, E_DECODE = 3'b010,
                         E_EXEC = 3'b011, E_MEM = 3'b100, E_WB = 3'b101, E_HALT = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_ack, dmem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, dmem_req, dmem_we, alu_en, gp_we_out, pc_we;
  logic [31:0] ir, retired;
  logic [2:0]  state;
  logic [1:0]  halt_cause;
  logic        dec_illegal, dec_mem_rren, dec_mem_wren, dec_gp_we;
  logic [5:0]  dec_op;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_retired;

  always #5 clk = ~clk;

  mc_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir),
    .dec_illegal(dec_illegal), .dec_mem_rren(dec_mem_rren), .dec_mem_wren(dec_mem_wren),
    .dec_gp_we(dec_gp_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_en(alu_en), .gp_we_out(gp_we_out), .pc_we(pc_we),
    .state(state), .halt_cause(halt_cause), .retired(retired)
  );

  // Minimal instruction decoder: R-type, lw, sw, plus a synthetic read+write opcode 0x3E.
  always_comb begin
    dec_op       = ir[31:26];
    dec_illegal  = 1'b1;
    dec_mem_rren = 1'b0;
    dec_mem_wren = 1'b0;
    dec_gp_we    = 1'b0;
    case (dec_op)
      6'h00: begin dec_illegal = 1'b0; dec_gp_we = 1'b1; end
      6'h23: begin dec_illegal = 1'b0; dec_mem_rren = 1'b1; dec_gp_we = 1'b1; end
      6'h2B: begin dec_illegal = 1'b0; dec_mem_wren = 1'b1; end
      6'h3E: begin dec_illegal = 1'b0; dec_mem_rren = 1'b1; dec_mem_wren = 1'b1; end
      default: ;
    endcase
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    step; step;
    rst_n = 1'b1;
    exp_retired = 32'd0;
  endtask

  // From IDLE: one cycle with run=1 puts the sequencer in FETCH.
  task automatic start_fetch;
    run = 1'b1;
    step;
  endtask

  function automatic logic [31:0] rand_instr(input int t);
    logic [31:0] w;
    w = $urandom;
    case (t)
      0: w[31:26] = 6'h00;
      1: w[31:26] = 6'h23;
      2: w[31:26] = 6'h2B;
      default: w[31:26] = 6'h3E;
    endcase
    return w;
  endfunction

  // Runs one instruction starting in a fresh FETCH cycle; id/dd are extra ack wait cycles.
  task automatic run_instr(input logic [31:0] instr, input int id, input int dd, input bit run_next);
    logic [2:0] exp_q[$];
    logic [5:0] op;
    logic [5:0] exp_strb;
    bit is_mem, is_wr, gpw;
    op     = instr[31:26];
    is_mem = (op == 6'h23) || (op == 6'h2B) || (op == 6'h3E);
    is_wr  = (op == 6'h2B) || (op == 6'h3E);
    gpw    = (op == 6'h00) || (op == 6'h23);
    for (int i = 0; i <= id; i++) exp_q.push_back(E_FETCH);
    exp_q.push_back(E_DECODE);
    exp_q.push_back(E_EXEC);
    if (is_mem) for (int i = 0; i <= dd; i++) exp_q.push_back(E_MEM);
    exp_q.push_back(E_WB);
    for (int k = 0; k < exp_q.size(); k++) begin
      imem_rdata = (exp_q[k] == E_FETCH) ? instr : $urandom;
      imem_ack   = (exp_q[k] == E_FETCH) ? (k == id) : 1'($urandom_range(0, 1));
      dmem_ack   = (exp_q[k] == E_MEM) ? (k == id + 3 + dd) : 1'($urandom_range(0, 1));
      run        = (exp_q[k] == E_WB) ? run_next : 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_strb = {exp_q[k] == E_FETCH, exp_q[k] == E_MEM, (exp_q[k] == E_MEM) && is_wr,
                  exp_q[k] == E_EXEC, (exp_q[k] == E_WB) && gpw, exp_q[k] == E_WB};
      checks++;
      if (state !== exp_q[k]) begin
        errors++;
        $display("FAIL instr_state instr=%h cyc=%0d got=%b exp=%b", instr, k, state, exp_q[k]);
      end
      checks++;
      if ({imem_req, dmem_req, dmem_we, alu_en, gp_we_out, pc_we} !== exp_strb) begin
        errors++;
        $display("FAIL instr_strobes instr=%h cyc=%0d got=%b exp=%b", instr, k,
                 {imem_req, dmem_req, dmem_we, alu_en, gp_we_out, pc_we}, exp_strb);
      end
      step;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    exp_retired = exp_retired + 32'd1;
    checks++;
    if (retired !== exp_retired) begin
      errors++;
      $display("FAIL retired instr=%h got=%0d exp=%0d", instr, retired, exp_retired);
    end
    checks++;
    if (ir !== instr) begin
      errors++;
      $display("FAIL ir_latch got=%h exp=%h", ir, instr);
    end
    checks++;
    if (state !== (run_next ? E_FETCH : E_IDLE)) begin
      errors++;
      $display("FAIL after_wb got=%b exp=%b", state, run_next ? E_FETCH : E_IDLE);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
    exp_retired = 32'd0;
    #3;
    checks++;
    if ({state, halt_cause, ir, retired} !== {E_IDLE, 2'b00, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_regs got state=%b cause=%b ir=%h ret=%0d", state, halt_cause, ir, retired);
    end
    checks++;
    if ({imem_req, dmem_req, dmem_we, alu_en, gp_we_out, pc_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got=%b exp=000000", {imem_req, dmem_req, dmem_we, alu_en, gp_we_out, pc_we});
    end
    step; step;
    rst_n = 1'b1;
    // IDLE must hold while run is low.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (state !== E_IDLE || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold got state=%b req=%b exp=000/0", state, imem_req);
      end
      step;
    end
  endtask

  task automatic test_add;
    do_reset;
    start_fetch;
    run_instr(32'h0022_1820, 0, 0, 1'b1);
    run_instr(32'h0043_2020, 0, 0, 1'b0);
  endtask

  task automatic test_load_store;
    do_reset;
    start_fetch;
    run_instr(32'h8C22_0004, 0, 3, 1'b1);
    run_instr(32'hAC22_0004, 0, 0, 1'b1);
    run_instr(32'hF822_0004, 1, 1, 1'b0);
  endtask

  task automatic test_back_to_back;
    bit rn;
    do_reset;
    start_fetch;
    for (int n = 0; n < 40; n++) begin
      rn = (n == 39) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      run_instr(rand_instr($urandom_range(0, 3)), $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), rn);
      if (!rn && n != 39) begin
        run = 1'b0;
        for (int w = $urandom_range(0, 2); w > 0; w--) step;
        start_fetch;
      end
    end
  endtask

  task automatic test_illegal;
    do_reset;
    start_fetch;
    imem_rdata = 32'hFC00_0000;
    imem_ack = 1'b1;
    step;
    imem_ack = 1'b0;
    checks++;
    if (state !== E_DECODE) begin
      errors++;
      $display("FAIL illegal_decode got=%b exp=%b", state, E_DECODE);
    end
    step;
    checks++;
    if (state !== E_HALT || halt_cause !== 2'b01) begin
      errors++;
      $display("FAIL illegal_halt got state=%b cause=%b exp=111/01", state, halt_cause);
    end
    for (int k = 0; k < 8; k++) begin
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      run = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({state, halt_cause, imem_req, dmem_req, dmem_we, alu_en, gp_we_out, pc_we} !==
          {E_HALT, 2'b01, 6'b0} || ir !== 32'hFC00_0000 || retired !== 32'd0) begin
        errors++;
        $display("FAIL halt_sticky got state=%b cause=%b ir=%h ret=%0d pc_we=%b", state,
                 halt_cause, ir, retired, pc_we);
      end
      step;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== E_IDLE || halt_cause !== 2'b00) begin
      errors++;
      $display("FAIL halt_reset got state=%b cause=%b exp=000/00", state, halt_cause);
    end
    do_reset;
  endtask

  task automatic test_imem_timeout;
    do_reset;
    start_fetch;
    imem_ack = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      checks++;
      if (state !== E_FETCH || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL imem_wait cyc=%0d got state=%b req=%b exp=001/1", k, state, imem_req);
      end
      step;
    end
    checks++;
    if (state !== E_HALT || halt_cause !== 2'b10 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL imem_timeout got state=%b cause=%b req=%b exp=111/10/0", state, halt_cause, imem_req);
    end
    // Ack on the last permitted cycle of both handshakes must not fault.
    do_reset;
    start_fetch;
    run_instr(32'h8C22_0004, TO - 1, TO - 1, 1'b0);
    checks++;
    if (halt_cause !== 2'b00) begin
      errors++;
      $display("FAIL timeout_edge got cause=%b exp=00", halt_cause);
    end
  endtask

  task automatic test_dmem_timeout;
    do_reset;
    start_fetch;
    imem_rdata = 32'hAC22_0004;
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    step;
    imem_ack = 1'b0;
    step; step;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      checks++;
      if ({state, dmem_req, dmem_we} !== {E_MEM, 2'b11}) begin
        errors++;
        $display("FAIL dmem_wait cyc=%0d got state=%b req=%b we=%b exp=100/1/1", k, state, dmem_req, dmem_we);
      end
      step;
    end
    checks++;
    if (state !== E_HALT || halt_cause !== 2'b11 || dmem_req !== 1'b0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL dmem_timeout got state=%b cause=%b req=%b ret=%0d exp=111/11/0/0", state,
               halt_cause, dmem_req, retired);
    end
  endtask

  task automatic test_async_reset_mem;
    do_reset;
    start_fetch;
    run_instr(32'h0022_1820, 0, 0, 1'b1);
    imem_rdata = 32'h8C22_0004;
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    step;
    imem_ack = 1'b0;
    step; step; step;
    @(negedge clk);
    checks++;
    if (state !== E_MEM || dmem_req !== 1'b1 || retired !== 32'd1) begin
      errors++;
      $display("FAIL pre_reset got state=%b req=%b ret=%0d exp=100/1/1", state, dmem_req, retired);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || state !== E_IDLE || retired !== 32'd0 || ir !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got req=%b state=%b ret=%0d ir=%h exp=0/000/0/0", dmem_req,
               state, retired, ir);
    end
    do_reset;
  endtask

  initial begin
    test_reset;
    test_add;
    test_load_store;
    test_back_to_back;
    test_illegal;
    test_imem_timeout;
    test_dmem_timeout;
    test_async_reset_mem;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
